collision_matrix: RTL and testbench

- Parametrised per-frame collision engine for the main game screen.
- Compares the ball draw request against NUM_OBJ-1 other object draw requests every pixel.
- Emits one-shot collision pulses with per-channel frame cooldown, plus a previous-frame summary.
- Adds channel enable masking and multi-frame suppression, so bouncing objects cannot retrigger on consecutive frames.

---
 rtl/collision_pkg.sv | 23 ++
 rtl/collision_channel.sv | 102 ++++++++++
 rtl/collision_matrix.sv | 55 +++++
 tb/tb_collision_matrix.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Object channel indices and per-channel state encoding shared by the collision engine.
package collision_pkg;

    localparam int OBJ_BALL         = 0;
    localparam int OBJ_FRAME        = 1;
    localparam int OBJ_FLIPPER      = 2;
    localparam int OBJ_OBSTACLE     = 3;
    localparam int OBJ_SPRING       = 4;
    localparam int OBJ_BUMPER       = 5;
    localparam int OBJ_SCORE_NUMBER = 6;
    localparam int OBJ_BOTTOM       = 7;
    localparam int OBJ_CREDIT       = 8;
    localparam int OBJ_SPARE        = 9;

    localparam int NUM_OBJ_DEFAULT  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        COOL = 2'd2
    } chan_state_t;

endpackage

// File: rtl/collision_channel.sv
// One ball-vs-object collision channel: pulse gate FSM, frame cooldown, frame flag and
// (with COLLISION_MATRIX_COUNT_EN) a saturating overlap pixel counter.
module collision_channel
    import collision_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 12
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             hit,
    output logic             collisionPulse,
    output logic             collisionLatched,
    output logic [CNT_W-1:0] overlapCount
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    chan_state_t     state, stateNext, frameState;
    logic [CD_W-1:0] cooldown, cooldownNext, frameCooldown;
    logic            pulseNext;
    logic            frameFlag;

    // Frame-boundary transitions resolve first, so a hit on the boundary pixel sees the new frame's state.
    always_comb begin
        frameState    = state;
        frameCooldown = cooldown;
        if (startOfFrame) begin
            unique case (state)
                HIT: begin
                    frameState = (cooldown != '0) ? COOL : IDLE;
                end
                COOL: begin
                    if (cooldown > CD_W'(1)) begin
                        frameCooldown = cooldown - 1'b1;
                        frameState    = COOL;
                    end else begin
                        frameCooldown = '0;
                        frameState    = IDLE;
                    end
                end
                default: begin
                    frameState = state;
                end
            endcase
        end

        stateNext    = frameState;
        cooldownNext = frameCooldown;
        pulseNext    = 1'b0;
        if ((frameState == IDLE) && hit) begin
            stateNext    = HIT;
            cooldownNext = CD_LOAD;
            pulseNext    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            cooldown         <= '0;
            collisionPulse   <= 1'b0;
            frameFlag        <= 1'b0;
            collisionLatched <= 1'b0;
        end else begin
            state          <= stateNext;
            cooldown       <= cooldownNext;
            collisionPulse <= pulseNext;
            if (startOfFrame) begin
                collisionLatched <= frameFlag;
                frameFlag        <= hit;
            end else begin
                frameFlag <= frameFlag | hit;
            end
        end
    end

`ifdef COLLISION_MATRIX_COUNT_EN
    logic [CNT_W-1:0] count;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count        <= '0;
            overlapCount <= '0;
        end else if (startOfFrame) begin
            overlapCount <= count;
            count        <= CNT_W'(hit);
        end else if (hit) begin
            count <= satInc(count);
        end
    end
`else
    assign overlapCount = '0;
`endif

endmodule

// File: rtl/collision_matrix.sv
// Per-frame ball collision engine: fans the ball overlap out to one channel per object.
// Define COLLISION_MATRIX_COUNT_EN to build the per-channel overlap pixel counters.
module collision_matrix
    import collision_pkg::*;
#(
    parameter int NUM_OBJ         = NUM_OBJ_DEFAULT,
    parameter int BALL_IDX        = OBJ_BALL,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 12
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_OBJ-1:0]       drawObj,
    input  logic [NUM_OBJ-1:0]       channelEnable,
    output logic [NUM_OBJ-1:0]       collisionPulse,
    output logic [NUM_OBJ-1:0]       collisionLatched,
    output logic                     anyCollision,
    output logic [NUM_OBJ*CNT_W-1:0] overlapCount
);

    logic ballDraw;
    logic unusedBallEnable;

    assign ballDraw         = drawObj[BALL_IDX];
    assign unusedBallEnable = channelEnable[BALL_IDX];

    // The ball never collides with itself, so its output bits are tied low.
    for (genvar i = 0; i < NUM_OBJ; i++) begin : gChan
        if (i == BALL_IDX) begin : gBall
            assign collisionPulse[i]               = 1'b0;
            assign collisionLatched[i]             = 1'b0;
            assign overlapCount[i*CNT_W +: CNT_W] = '0;
        end else begin : gObj
            logic hit;
            assign hit = ballDraw & drawObj[i] & channelEnable[i];

            collision_channel #(
                .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
                .CNT_W           (CNT_W)
            ) uChan (
                .clk              (clk),
                .resetN           (resetN),
                .startOfFrame     (startOfFrame),
                .hit              (hit),
                .collisionPulse   (collisionPulse[i]),
                .collisionLatched (collisionLatched[i]),
                .overlapCount     (overlapCount[i*CNT_W +: CNT_W])
            );
        end
    end

    assign anyCollision = |collisionPulse;

endmodule

// File: tb/tb_collision_matrix.sv
// Directed bench for collision_matrix with hand-computed expectations.
module tb_collision_matrix;
    import collision_pkg::*;

    localparam int N  = 10;
    localparam int CW = 12;

`ifdef COLLISION_MATRIX_COUNT_EN
    localparam logic [63:0] BUMPER_CNT = 64'd5;
`else
    localparam logic [63:0] BUMPER_CNT = 64'd0;
`endif

    logic            clk           = 1'b0;
    logic            resetN        = 1'b1;
    logic            startOfFrame  = 1'b0;
    logic [N-1:0]    drawObj       = '0;
    logic [N-1:0]    channelEnable = '1;
    logic [N-1:0]    collisionPulse;
    logic [N-1:0]    collisionLatched;
    logic            anyCollision;
    logic [N*CW-1:0] overlapCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    collision_matrix #(
        .NUM_OBJ         (N),
        .BALL_IDX        (OBJ_BALL),
        .COOLDOWN_FRAMES (2),
        .CNT_W           (CW)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .drawObj          (drawObj),
        .channelEnable    (channelEnable),
        .collisionPulse   (collisionPulse),
        .collisionLatched (collisionLatched),
        .anyCollision     (anyCollision),
        .overlapCount     (overlapCount)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one pixel, then sample #1 after the clock edge that registers it.
    task automatic pixel(input logic sof, input logic [N-1:0] draw);
        startOfFrame = sof;
        drawObj      = draw;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        drawObj      = '0;
    endtask

    initial begin
        #1 resetN = 1'b0;
        pixel(1'b0, '0);
        pixel(1'b0, '0);
        checkVal("rst_pulse", 64'(collisionPulse), 64'h000);
        checkVal("rst_latched", 64'(collisionLatched), 64'h000);
        checkVal("rst_any", 64'(anyCollision), 64'h0);
        checkVal("rst_count", 64'(|overlapCount), 64'h0);
        resetN = 1'b1;

        // Bumper overlaps for five pixels in frame 0
        pixel(1'b0, 10'h021);
        checkVal("bump_first_pulse", 64'(collisionPulse), 64'h020);
        checkVal("bump_first_any", 64'(anyCollision), 64'h1);
        for (int k = 0; k < 4; k++) begin
            pixel(1'b0, 10'h021);
            checkVal("bump_repeat_pulse", 64'(collisionPulse), 64'h000);
        end
        pixel(1'b0, '0);
        checkVal("bump_latched_before_sof", 64'(collisionLatched), 64'h000);
        pixel(1'b1, '0);
        checkVal("bump_latched", 64'(collisionLatched), 64'h020);
        checkVal("bump_count", 64'(overlapCount[OBJ_BUMPER*CW +: CW]), BUMPER_CNT);
        pixel(1'b0, '0);
        checkVal("bump_latched_stable", 64'(collisionLatched), 64'h020);

        // Flipper across four frames with a two-frame cooldown
        pixel(1'b0, 10'h005);
        checkVal("flip_f0_pulse", 64'(collisionPulse), 64'h004);
        pixel(1'b1, '0);
        checkVal("flip_f0_latched", 64'(collisionLatched), 64'h004);
        pixel(1'b0, 10'h005);
        checkVal("flip_f1_pulse", 64'(collisionPulse), 64'h000);
        pixel(1'b1, '0);
        checkVal("flip_f1_latched", 64'(collisionLatched), 64'h004);
        pixel(1'b0, 10'h005);
        checkVal("flip_f2_pulse", 64'(collisionPulse), 64'h000);
        pixel(1'b1, 10'h005);
        checkVal("flip_f3_sof_pulse", 64'(collisionPulse), 64'h004);
        checkVal("flip_f2_latched", 64'(collisionLatched), 64'h004);
        pixel(1'b0, 10'h005);
        checkVal("flip_f3_repeat", 64'(collisionPulse), 64'h000);
        pixel(1'b1, '0);
        checkVal("flip_f3_latched", 64'(collisionLatched), 64'h004);

        // Frame-object overlap coincident with startOfFrame
        pixel(1'b0, '0);
        pixel(1'b1, 10'h003);
        checkVal("sof_hit_pulse", 64'(collisionPulse), 64'h002);
        checkVal("sof_hit_not_latched", 64'(collisionLatched), 64'h000);
        pixel(1'b0, '0);
        checkVal("sof_hit_pulse_gone", 64'(collisionPulse), 64'h000);
        pixel(1'b1, '0);
        checkVal("sof_hit_latched", 64'(collisionLatched), 64'h002);

        // Credit channel disabled for a frame, then re-enabled
        channelEnable = 10'h2FF;
        pixel(1'b0, 10'h101);
        checkVal("credit_off_pulse0", 64'(collisionPulse), 64'h000);
        pixel(1'b0, 10'h101);
        checkVal("credit_off_pulse1", 64'(collisionPulse), 64'h000);
        channelEnable = '1;
        pixel(1'b1, '0);
        checkVal("credit_off_latched", 64'(collisionLatched), 64'h000);
        pixel(1'b0, 10'h101);
        checkVal("credit_on_pulse", 64'(collisionPulse), 64'h100);
        pixel(1'b0, 10'h101);
        checkVal("credit_on_repeat", 64'(collisionPulse), 64'h000);
        pixel(1'b1, '0);
        checkVal("credit_on_latched", 64'(collisionLatched), 64'h100);

        // Obstacle and spring in the same cycle, then every object at once
        pixel(1'b0, 10'h019);
        checkVal("dual_pulse", 64'(collisionPulse), 64'h018);
        checkVal("dual_any", 64'(anyCollision), 64'h1);
        pixel(1'b0, '0);
        checkVal("dual_pulse_gone", 64'(collisionPulse), 64'h000);
        checkVal("dual_any_gone", 64'(anyCollision), 64'h0);
        pixel(1'b0, 10'h001);
        checkVal("ball_only_pulse", 64'(collisionPulse), 64'h000);
        pixel(1'b0, 10'h3FF);
        checkVal("all_draw_pulse", 64'(collisionPulse), 64'h2E6);
        pixel(1'b1, '0);
        checkVal("all_draw_latched", 64'(collisionLatched), 64'h3FE);

        // Reset mid-frame while the obstacle is cooling down
        pixel(1'b0, '0);
        #2 resetN = 1'b0;
        #1;
        checkVal("midrst_latched", 64'(collisionLatched), 64'h000);
        checkVal("midrst_pulse", 64'(collisionPulse), 64'h000);
        checkVal("midrst_any", 64'(anyCollision), 64'h0);
        checkVal("midrst_count", 64'(|overlapCount), 64'h0);
        @(posedge clk);
        #1 resetN = 1'b1;
        checkVal("postrst_latched", 64'(collisionLatched), 64'h000);
        pixel(1'b0, 10'h009);
        checkVal("postrst_obstacle_pulse", 64'(collisionPulse), 64'h008);
        checkVal("postrst_any", 64'(anyCollision), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
